// File: rtl/video_pkg.sv
// Shared definitions for the vertical filter: mode encodings and channel slicing.
package video_pkg;

  typedef enum logic [1:0] {
    VF_MODE_BYPASS = 2'd0,
    VF_MODE_3TAP   = 2'd1,
    VF_MODE_2TAP   = 2'd2,
    VF_MODE_RSVD   = 2'd3
  } vf_mode_e;

  // Saturation point of the line counter; only 0, 1 and >=2 matter to the taps.
  localparam logic [1:0] VF_Y_SAT = 2'd3;

  function automatic int ch_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction

endpackage

// File: rtl/video_line_ram.sv
// Single-write, asynchronous-read line buffer; read and write share one address.
module video_line_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/video_vfilter.sv
// Vertical line filter: two line buffers feed a per-channel 3-tap / 2-tap / bypass
// stage with top-edge replication and a single registered valid/ready output.
module video_vfilter
  import video_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int LINE_WIDTH   = 640,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEFAULT_MODE = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic                           in_sol,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sof,
  output logic                           out_sol,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data
);

  localparam int W      = CHANNELS * DATA_WIDTH;
  localparam int RAM_AW = $clog2(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_WIDTH - 1);

  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [1:0]            y_q, y_d;
  logic                  wrap_q, wrap_d;
  logic [1:0]            mode_q, mode_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_sol_q, out_sol_d;
  logic [W-1:0]          out_data_q, out_data_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] col;
  logic [1:0]            y_eff;
  logic [1:0]            mode_eff;
  logic [W-1:0]          l1_rd, l2_rd;
  logic [W-1:0]          tap_a, tap_b, tap_c;
  logic [W-1:0]          f3, f2, filt;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  video_line_ram #(.WIDTH(W), .DEPTH(LINE_WIDTH), .AW(RAM_AW)) u_l1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col[RAM_AW-1:0]),
    .wdata (in_data),
    .rdata (l1_rd)
  );

  video_line_ram #(.WIDTH(W), .DEPTH(LINE_WIDTH), .AW(RAM_AW)) u_l2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col[RAM_AW-1:0]),
    .wdata (l1_rd),
    .rdata (l2_rd)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam int LSB = ch_lsb(g, DATA_WIDTH);
    logic [DATA_WIDTH+1:0] sum3;
    logic [DATA_WIDTH:0]   sum2;

    assign sum3 = {2'b00, tap_a[LSB +: DATA_WIDTH]}
                + {1'b0, tap_b[LSB +: DATA_WIDTH], 1'b0}
                + {2'b00, tap_c[LSB +: DATA_WIDTH]}
                + (DATA_WIDTH+2)'(2);
    assign sum2 = {1'b0, tap_b[LSB +: DATA_WIDTH]}
                + {1'b0, tap_c[LSB +: DATA_WIDTH]}
                + (DATA_WIDTH+1)'(1);

    assign f3[LSB +: DATA_WIDTH] = DATA_WIDTH'(sum3 >> 2);
    assign f2[LSB +: DATA_WIDTH] = DATA_WIDTH'(sum2 >> 1);
  end

  always_comb begin
    col      = x_q;
    y_eff    = y_q;
    mode_eff = mode_q;
    // A wrap at the end of the previous line and an explicit sol count as one new line.
    if (in_sof) begin
      col      = '0;
      y_eff    = 2'd0;
      mode_eff = mode;
    end else if (in_sol || wrap_q) begin
      col   = in_sol ? '0 : x_q;
      y_eff = (y_q == VF_Y_SAT) ? VF_Y_SAT : y_q + 2'd1;
    end

    tap_c = in_data;
    tap_a = in_data;
    tap_b = in_data;
    case (y_eff)
      2'd0:    begin tap_a = in_data; tap_b = in_data; end
      2'd1:    begin tap_a = l1_rd;   tap_b = l1_rd;   end
      default: begin tap_a = l2_rd;   tap_b = l1_rd;   end
    endcase

    case (mode_eff)
      VF_MODE_3TAP: filt = f3;
      VF_MODE_2TAP: filt = f2;
      default:      filt = tap_c;
    endcase

    x_d         = x_q;
    y_d         = y_q;
    wrap_d      = wrap_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_sol_d   = out_sol_q;
    out_data_d  = out_data_q;

    if (accept) begin
      x_d         = (col == LAST_COL) ? '0 : col + 1'b1;
      wrap_d      = (col == LAST_COL);
      y_d         = y_eff;
      mode_d      = mode_eff;
      out_valid_d = 1'b1;
      out_sof_d   = in_sof;
      out_sol_d   = in_sol;
      out_data_d  = filt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= 2'd0;
      wrap_q      <= 1'b0;
      mode_q      <= 2'(DEFAULT_MODE);
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_sol_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_sol_q   <= out_sol_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_sol   = out_sol_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_video_vfilter.sv
// Scoreboard bench for video_vfilter with 4-pixel lines and two 8-bit channels.
module tb_video_vfilter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_sol = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic        out_sof;
  logic        out_sol;
  logic [15:0] out_data;

  logic [17:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          outs = 0;
  int          pushes = 0;
  logic        hold_vld = 1'b0;
  logic [17:0] hold_val = '0;

  video_vfilter #(
    .CHANNELS(2), .DATA_WIDTH(8), .LINE_WIDTH(4), .ADDR_WIDTH(2), .DEFAULT_MODE(1)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_sol(in_sol), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_sol(out_sol), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] px(input int c1, input int c0);
    return {8'(c1), 8'(c0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per consumed beat and checks hold while stalled.
  always @(negedge clk) begin
    if (!reset) begin
      if (hold_vld) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_beat", {14'd0, out_sof, out_sol, out_data}, {14'd0, hold_val});
      end
      hold_vld = 1'b0;
      if (out_valid && out_ready) begin
        outs++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", {out_sof, out_sol, out_data});
        end else begin
          chk("out_beat", {14'd0, out_sof, out_sol, out_data}, {14'd0, exp_q.pop_front()});
        end
      end else if (out_valid) begin
        hold_vld = 1'b1;
        hold_val = {out_sof, out_sol, out_data};
      end
    end
  end

  task automatic send(input logic sof, input logic sol, input logic [15:0] d, input logic [15:0] e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_sol   = sol;
    in_data  = d;
    exp_q.push_back({sof, sol, e});
    pushes++;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic line(input logic sof, input logic sol, input logic [15:0] d, input logic [15:0] e,
                      input int n);
    for (int i = 0; i < n; i++) send(sof && (i == 0), sol && (i == 0), d, e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_sof", {31'd0, out_sof}, 32'd0);
    chk("rst_out_sol", {31'd0, out_sol}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Constant field stays constant through the filter.
    mode = 2'd1;
    line(1'b1, 1'b0, px(100, 100), px(100, 100), 4);
    line(1'b0, 1'b1, px(100, 100), px(100, 100), 4);
    line(1'b0, 1'b1, px(100, 100), px(100, 100), 4);

    // Ramp with top replication; third line starts by implicit wrap.
    line(1'b1, 1'b0, px(200, 0),  px(200, 0),  4);
    line(1'b0, 1'b1, px(100, 40), px(175, 10), 4);
    line(1'b0, 1'b0, px(0, 80),   px(100, 40), 4);

    // Two-tap, including the top of the sample range.
    mode = 2'd2;
    line(1'b1, 1'b0, px(255, 10), px(255, 10), 4);
    line(1'b0, 1'b1, px(254, 13), px(255, 12), 4);

    // Bypass, with sof and sol together on the first beat.
    mode = 2'd0;
    send(1'b1, 1'b1, px(9, 8),     px(9, 8));
    send(1'b0, 1'b0, px(17, 33),   px(17, 33));
    send(1'b0, 1'b0, px(250, 1),   px(250, 1));
    send(1'b0, 1'b0, px(128, 127), px(128, 127));
    send(1'b0, 1'b1, px(3, 200),   px(3, 200));

    // Reserved mode behaves as bypass.
    mode = 2'd3;
    line(1'b1, 1'b0, px(10, 20), px(10, 20), 4);
    line(1'b0, 1'b1, px(50, 60), px(50, 60), 4);

    // Mode port change only takes effect at the next sof.
    mode = 2'd1;
    line(1'b1, 1'b0, px(0, 0), px(0, 0), 4);
    mode = 2'd2;
    line(1'b0, 1'b1, px(40, 40), px(10, 10), 4);
    line(1'b1, 1'b0, px(60, 60), px(60, 60), 4);
    line(1'b0, 1'b1, px(20, 20), px(40, 40), 4);

    // Downstream stall with a beat waiting upstream.
    mode = 2'd0;
    send(1'b1, 1'b0, px(1, 2), px(1, 2));
    send(1'b0, 1'b0, px(3, 4), px(3, 4));
    out_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    @(negedge clk);
    #2;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    send(1'b0, 1'b0, px(5, 6), px(5, 6));
    send(1'b0, 1'b0, px(7, 8), px(7, 8));

    // Reset in the middle of a line, then a fresh frame over stale line RAM.
    mode = 2'd1;
    send(1'b1, 1'b0, px(50, 50), px(50, 50));
    send(1'b0, 1'b0, px(51, 51), px(51, 51));
    idle();
    repeat (3) @(negedge clk);
    do_reset();
    line(1'b1, 1'b0, px(200, 200), px(200, 200), 4);
    line(1'b0, 1'b1, px(100, 100), px(175, 175), 2);
    line(1'b0, 1'b1, px(0, 0),     px(100, 100), 2);
    idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("beat_count", outs, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
